ysyx_22040931_lsu: RTL
======================

YSYX_22040931_LSU -- requirements
Module: ysyx_22040931_LSU

Interface
REQ-001 Parameter: ADDR_W, default 32, memory address width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  execute-stage bundle valid.
REQ-005 in_ready  output  1  LSU can accept a bundle this cycle.
REQ-006 mem_ena_i, mem_wr_i  input  1 each  memory access enable; 1 = store, 0 = load.
REQ-007 memwop_i, memrop_i  input  3 each  store / load size opcode.
REQ-008 mem_addr_i  input  ADDR_W  byte address.
REQ-009 mem_data_i  input  64  store data.
REQ-010 w_ena_i, w_addr_i, w_data_i  input  1/5/64  register writeback from execute.
REQ-011 pc_i, instr_i  input  64/32  pipeline tags.
REQ-012 bus_req, bus_we  output  1 each  bus request; write qualifier.
REQ-013 bus_addr  output  ADDR_W  address with bits [2:0] forced to 0.
REQ-014 bus_wdata, bus_wstrb  output  64/8  lane-aligned write data and byte strobes.
REQ-015 bus_ack, bus_rdata  input  1/64  completion; read doubleword, valid with ack.
REQ-016 out_valid  output  1  writeback bundle valid, one-cycle pulse.
REQ-017 w_ena, w_addr, w_data, pc_o, instr_o  output  1/5/64/64/32  writeback bundle.
REQ-018 misalign_o  output  1  misaligned-access pulse.

Function
REQ-019 The FSM SHALL use states IDLE, WAIT and RESP; in_ready SHALL be 1 only in IDLE.
REQ-020 A bundle SHALL be accepted when in_valid and in_ready are both 1; all fields are registered.
REQ-021 For an accepted bundle with mem_ena_i=0, the next state SHALL be RESP; w_data = w_data_i; bus_req stays 0.
REQ-022 For an accepted bundle with mem_ena_i=1, the next state SHALL be WAIT; bus_req = 1 throughout WAIT; bus outputs stay stable until ack.
REQ-023 In WAIT, a sampled bus_ack=1 SHALL move the FSM to RESP; bus_ack sampled while bus_req=0 SHALL be ignored.
REQ-024 In RESP, out_valid SHALL be 1 for exactly one cycle, after which the FSM returns to IDLE.
REQ-025 Latency: accept at cycle N with ack at N+1 gives out_valid at N+2; a non-memory bundle gives out_valid at N+1.
REQ-026 memwop encoding: 0 none, 1 SB, 2 SH, 3 SW, 4 SD; memrop encoding: 0 none, 1 LB, 2 LH, 3 LW, 4 LD, 5 LBU, 6 LHU, 7 LWU.
REQ-027 For a store, with off = addr[2:0]: bus_wdata = mem_data_i << 8*off; bus_wstrb = 0x01/0x03/0x0F/0xFF << off for SB/SH/SW/SD; w_ena out = 0.
REQ-028 For a load: shift bus_rdata right by 8*off, take the low 8/16/32/64 bits, then sign-extend (LB/LH/LW) or zero-extend (LBU/LHU/LWU) to 64; w_data holds the result.
REQ-029 Read data SHALL be captured on the ack cycle and held through RESP.
REQ-030 pc_o, instr_o, w_addr and w_ena SHALL be the registered input values unless REQ-027 or REQ-033 overrides them.

Reset
REQ-031 rst=1 SHALL force, without a clock edge: state to IDLE; bus_req, bus_we, out_valid, w_ena and misalign_o to 0; all data outputs to 0.
REQ-032 Reset during WAIT SHALL drop bus_req immediately and discard the transaction; no out_valid is produced.

Configuration
REQ-033 With YSYX_22040931_MISALIGN_TRAP_EN defined, a misaligned access (SH/LH/LHU with off[0]!=0; word accesses with off[1:0]!=0; doubleword accesses with off!=0) SHALL skip WAIT and go to RESP with misalign_o=1, w_ena=0 and no bus_req.
REQ-034 With YSYX_22040931_MISALIGN_TRAP_EN undefined, misalign_o SHALL be tied 0; misaligned accesses are issued as in REQ-027/028, and lanes beyond byte 7 are dropped.

Verification
REQ-035 SD at addr 0x80000010, data 0x1122334455667788, ack after 3 cycles -> bus_addr 0x80000010, wstrb 0xFF, bus_req high 3 cycles, out_valid once with w_ena=0.
REQ-036 LB at addr 0x80000003, rdata 0x00000000_80FF0000 -> w_data 0xFFFFFFFFFFFFFF80; LBU at the same address -> 0x80.
REQ-037 SH at addr 0x80000006, data 0xABCD -> wstrb 0xC0, bus_wdata[63:48] = 0xABCD.
REQ-038 Non-memory bundle (w_data_i 0x5, w_addr 3) -> out_valid at N+1 with no bus_req; back-to-back bundles accepted every 2 cycles.
REQ-039 LW at addr 0x80000002 with macro defined -> misalign_o pulse and no bus_req; with macro undefined -> a bus access is issued.
REQ-040 Assert rst in the second WAIT cycle, then give a late ack -> bus_req low immediately, no out_valid, in_ready=1 after reset.

Source files
------------

// File: rtl/ysyx_22040931_lsu.sv
// ysyx_22040931_lsu -- load/store unit between execute and writeback.
//
// Accepts one execute bundle at a time (in_valid/in_ready handshake). Non-memory
// bundles pass straight to writeback one cycle later. Memory bundles issue one
// doubleword-aligned bus access (byte lanes selected by bus_wstrb for stores)
// and wait for bus_ack. For loads, the result is shifted, sign- or zero-extended
// and written back. Every bundle produces a single-cycle out_valid pulse.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   in_valid / in_ready           execute-side handshake
//   mem_ena_i, mem_wr_i           access enable, 1 = store / 0 = load
//   memwop_i, memrop_i            store / load size opcode
//   mem_addr_i, mem_data_i        byte address, store data
//   w_ena_i, w_addr_i, w_data_i   register writeback from execute
//   pc_i, instr_i                 pipeline tags
//   bus_req, bus_we, bus_addr,
//   bus_wdata, bus_wstrb          bus request, held stable until ack
//   bus_ack, bus_rdata            bus completion and read doubleword
//   out_valid, w_ena, w_addr,
//   w_data, pc_o, instr_o         writeback bundle
//   misalign_o                    misaligned-access pulse
//
// Optional feature: define YSYX_22040931_MISALIGN_TRAP_EN to trap misaligned
// accesses (no bus request, misalign_o pulse, writeback suppressed). Without it,
// misaligned accesses are issued and lanes past byte 7 are dropped.

module ysyx_22040931_lsu #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic              mem_ena_i,
    input  logic              mem_wr_i,
    input  logic [2:0]        memwop_i,
    input  logic [2:0]        memrop_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [63:0]       mem_data_i,
    input  logic              w_ena_i,
    input  logic [4:0]        w_addr_i,
    input  logic [63:0]       w_data_i,
    input  logic [63:0]       pc_i,
    input  logic [31:0]       instr_i,

    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [63:0]       bus_wdata,
    output logic [7:0]        bus_wstrb,
    input  logic              bus_ack,
    input  logic [63:0]       bus_rdata,

    output logic              out_valid,
    output logic              w_ena,
    output logic [4:0]        w_addr,
    output logic [63:0]       w_data,
    output logic [63:0]       pc_o,
    output logic [31:0]       instr_o,
    output logic              misalign_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic              accept;
    logic              mis_in;
    logic              mis_q;

    logic              is_store_q;
    logic              is_load_q;
    logic [2:0]        memwop_q;
    logic [2:0]        memrop_q;
    logic [ADDR_W-1:0] addr_q;
    logic [63:0]       sdata_q;
    logic              w_ena_q;
    logic [4:0]        w_addr_q;
    logic [63:0]       w_data_q;
    logic [63:0]       pc_q;
    logic [31:0]       instr_q;

    // Align the selected bytes of the returned doubleword to bit 0 and extend.
    // rop 0 (no load) leaves the writeback value untouched.
    function automatic logic [63:0] load_ext(input logic [2:0]  rop,
                                             input logic [2:0]  off,
                                             input logic [63:0] rdata,
                                             input logic [63:0] dflt);
        logic [63:0] sh;
        sh = rdata >> {off, 3'b000};
        case (rop)
            3'd1:    load_ext = {{56{sh[7]}},  sh[7:0]};
            3'd2:    load_ext = {{48{sh[15]}}, sh[15:0]};
            3'd3:    load_ext = {{32{sh[31]}}, sh[31:0]};
            3'd4:    load_ext = sh;
            3'd5:    load_ext = {56'd0, sh[7:0]};
            3'd6:    load_ext = {48'd0, sh[15:0]};
            3'd7:    load_ext = {32'd0, sh[31:0]};
            default: load_ext = dflt;
        endcase
    endfunction

    assign accept = in_valid & in_ready;

`ifdef YSYX_22040931_MISALIGN_TRAP_EN
    logic misalign_q;

    // Natural alignment check on the incoming bundle, sized by whichever opcode
    // applies to the access direction.
    function automatic logic is_misaligned(input logic       wr,
                                           input logic [2:0] wop,
                                           input logic [2:0] rop,
                                           input logic [2:0] off);
        logic half, word, dword;
        half  = wr ? (wop == 3'd2) : (rop == 3'd2 || rop == 3'd6);
        word  = wr ? (wop == 3'd3) : (rop == 3'd3 || rop == 3'd7);
        dword = wr ? (wop == 3'd4) : (rop == 3'd4);
        is_misaligned = (half  && off[0]   != 1'b0)  ||
                        (word  && off[1:0] != 2'b00) ||
                        (dword && off      != 3'b000);
    endfunction

    assign mis_in = mem_ena_i & is_misaligned(mem_wr_i, memwop_i, memrop_i, mem_addr_i[2:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            misalign_q <= 1'b0;
        else if (accept)
            misalign_q <= mis_in;
    end

    assign mis_q      = misalign_q;
    assign misalign_o = misalign_q & (state == RESP);
`else
    assign mis_in     = 1'b0;
    assign mis_q      = 1'b0;
    assign misalign_o = 1'b0;
`endif

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (mem_ena_i && !mis_in) ? WAIT : RESP;
            WAIT: if (bus_ack) state_nxt = RESP;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- bundle registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_store_q <= 1'b0;
            is_load_q  <= 1'b0;
            memwop_q   <= 3'd0;
            memrop_q   <= 3'd0;
            addr_q     <= '0;
            sdata_q    <= 64'd0;
            w_ena_q    <= 1'b0;
            w_addr_q   <= 5'd0;
            w_data_q   <= 64'd0;
            pc_q       <= 64'd0;
            instr_q    <= 32'd0;
        end else if (accept) begin
            is_store_q <= mem_ena_i & mem_wr_i;
            is_load_q  <= mem_ena_i & ~mem_wr_i;
            memwop_q   <= memwop_i;
            memrop_q   <= memrop_i;
            addr_q     <= mem_addr_i;
            sdata_q    <= mem_data_i;
            w_ena_q    <= w_ena_i;
            w_addr_q   <= w_addr_i;
            w_data_q   <= w_data_i;
            pc_q       <= pc_i;
            instr_q    <= instr_i;
        end else if (state == WAIT && bus_ack && is_load_q) begin
            // Read data is only valid with ack; capture it here and hold.
            w_data_q   <= load_ext(memrop_q, addr_q[2:0], bus_rdata, w_data_q);
        end
    end

    // ---------------- outputs ----------------
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == RESP);

    assign bus_req   = (state == WAIT);
    assign bus_we    = (state == WAIT) & is_store_q;
    assign bus_addr  = {addr_q[ADDR_W-1:3], 3'b000};
    // Shifting in a fixed 64/8-bit width drops lanes beyond byte 7.
    assign bus_wdata = sdata_q << {addr_q[2:0], 3'b000};

    always_comb begin
        bus_wstrb = 8'h00;
        if (is_store_q) begin
            case (memwop_q)
                3'd1:    bus_wstrb = 8'h01 << addr_q[2:0];
                3'd2:    bus_wstrb = 8'h03 << addr_q[2:0];
                3'd3:    bus_wstrb = 8'h0F << addr_q[2:0];
                3'd4:    bus_wstrb = 8'hFF << addr_q[2:0];
                default: bus_wstrb = 8'h00;
            endcase
        end
    end

    // Stores and trapped accesses never write a register.
    assign w_ena   = w_ena_q & ~is_store_q & ~mis_q;
    assign w_addr  = w_addr_q;
    assign w_data  = w_data_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule
